fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 103 ++++++++++
 tb/tb_fetch_unit.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch unit: alternates FETCH (memory request) and EXEC (decoder consumes instr).
// Optional macro MISALIGN_TRAP_EN adds a sticky TRAP state for misaligned taken branch targets.
module fetch_unit #(
    parameter int unsigned               DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0]     RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic                  imem_ack,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic [DATA_WIDTH-1:0] instr,
    output logic                  instr_valid,
    input  logic                  PCsrc,
    input  logic [DATA_WIDTH-1:0] ImmExt,
    input  logic                  stall,
    output logic [DATA_WIDTH-1:0] PC,
    output logic [DATA_WIDTH-1:0] PCPlus4,
    output logic                  trap
);

`ifdef MISALIGN_TRAP_EN
    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_TRAP} state_t;
`else
    typedef enum logic [1:0] {S_FETCH, S_EXEC} state_t;
`endif

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   pc_q, pc_d;
    logic [DATA_WIDTH-1:0]   instr_q, instr_d;
    logic [DATA_WIDTH-1:0]   pc_plus4;
    logic [DATA_WIDTH-1:0]   branch_tgt;

    assign pc_plus4   = pc_q + DATA_WIDTH'(4);
    assign branch_tgt = pc_q + ImmExt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        case (state_q)
            S_FETCH: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (!stall) begin
                    if (PCsrc) begin
`ifdef MISALIGN_TRAP_EN
                        // Misaligned target: freeze PC and park in TRAP until reset.
                        if (branch_tgt[1:0] != 2'b00) begin
                            state_d = S_TRAP;
                        end else begin
                            pc_d    = branch_tgt;
                            state_d = S_FETCH;
                        end
`else
                        pc_d    = {branch_tgt[DATA_WIDTH-1:2], 2'b00};
                        state_d = S_FETCH;
`endif
                    end else begin
                        pc_d    = pc_plus4;
                        state_d = S_FETCH;
                    end
                end
            end
`ifdef MISALIGN_TRAP_EN
            S_TRAP: state_d = S_TRAP;
`endif
            default: state_d = S_FETCH;
        endcase
    end

    // Gate with rst so the request drops the instant reset asserts.
    assign imem_req    = !rst && (state_q == S_FETCH);
    assign instr_valid = !rst && (state_q == S_EXEC);
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign PC          = pc_q;
    assign PCPlus4     = pc_plus4;

`ifdef MISALIGN_TRAP_EN
    assign trap = (state_q == S_TRAP);
`else
    assign trap = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized fetch/exec transactions
// checked against a transaction-level model of PC and instruction.
module tb_fetch_unit;
    localparam int unsigned W   = 32;
    localparam logic [31:0]  RPC = 32'h0000_0000;

    logic          clk = 1'b0;
    logic          rst;
    logic          imem_req;
    logic [W-1:0]  imem_addr;
    logic          imem_ack;
    logic [W-1:0]  imem_rdata;
    logic [W-1:0]  instr;
    logic          instr_valid;
    logic          PCsrc;
    logic [W-1:0]  ImmExt;
    logic          stall;
    logic [W-1:0]  PC;
    logic [W-1:0]  PCPlus4;
    logic          trap;

    fetch_unit #(.DATA_WIDTH(W), .RESET_PC(RPC)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr(instr), .instr_valid(instr_valid),
        .PCsrc(PCsrc), .ImmExt(ImmExt), .stall(stall),
        .PC(PC), .PCPlus4(PCPlus4), .trap(trap)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] m_pc;
    logic [31:0] m_instr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One fetch: dly cycles with no ack, then an ack carrying data.
    task automatic do_fetch(input int dly, input logic [31:0] data);
        for (int i = 0; i < dly; i++) begin
            imem_ack   = 1'b0;
            imem_rdata = $urandom;
            stall      = 1'($urandom);
            PCsrc      = 1'($urandom);
            ImmExt     = $urandom;
            chk("wait_req",   {31'd0, imem_req}, 32'd1);
            chk("wait_addr",  imem_addr, m_pc);
            chk("wait_valid", {31'd0, instr_valid}, 32'd0);
            chk("wait_instr", instr, m_instr);
            step();
        end
        imem_ack   = 1'b1;
        imem_rdata = data;
        chk("ack_req",   {31'd0, imem_req}, 32'd1);
        chk("ack_addr",  imem_addr, m_pc);
        chk("ack_pc",    PC, m_pc);
        chk("ack_pc4",   PCPlus4, m_pc + 32'd4);
        chk("ack_trap",  {31'd0, trap}, 32'd0);
        step();
        imem_ack = 1'b0;
        m_instr  = data;
    endtask

    // One execute: stalls cycles held, then release with the given branch decision.
    task automatic do_exec(input int stalls, input bit take, input logic [31:0] imm);
        logic [31:0] tgt;
        for (int i = 0; i < stalls; i++) begin
            stall      = 1'b1;
            imem_ack   = 1'($urandom);
            imem_rdata = $urandom;
            PCsrc      = 1'($urandom);
            ImmExt     = $urandom;
            chk("stall_valid", {31'd0, instr_valid}, 32'd1);
            chk("stall_req",   {31'd0, imem_req}, 32'd0);
            chk("stall_instr", instr, m_instr);
            chk("stall_pc",    PC, m_pc);
            step();
        end
        stall      = 1'b0;
        imem_ack   = 1'($urandom);
        imem_rdata = $urandom;
        PCsrc      = take;
        ImmExt     = imm;
        chk("exec_valid", {31'd0, instr_valid}, 32'd1);
        chk("exec_req",   {31'd0, imem_req}, 32'd0);
        chk("exec_instr", instr, m_instr);
        chk("exec_pc",    PC, m_pc);
        step();
        imem_ack = 1'b0;
        PCsrc    = 1'b0;
        tgt      = m_pc + imm;
        if (take) m_pc = tgt & 32'hFFFF_FFFC;
        else      m_pc = m_pc + 32'd4;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        #1;
        m_pc    = RPC;
        m_instr = 32'd0;
        chk("rst_req",   {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_pc",    PC, RPC);
        chk("rst_instr", instr, 32'd0);
        chk("rst_trap",  {31'd0, trap}, 32'd0);
        step();
        step();
        rst = 1'b0;
        #1;
        chk("rel_req",  {31'd0, imem_req}, 32'd1);
        chk("rel_addr", imem_addr, RPC);
    endtask

    initial begin
        rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0;
        PCsrc = 1'b0; ImmExt = '0; stall = 1'b0;
        m_pc = RPC; m_instr = 32'd0;
        step();
        apply_reset();

        // Zero-wait memory: addresses 0,4,8 with valid every other cycle.
        for (int k = 0; k < 3; k++) begin
            do_fetch(0, $urandom);
            do_exec(0, 1'b0, 32'd0);
        end
        chk("seq_addr_after3", imem_addr, 32'd12);

        // Walk to 0x10, then branch by -8 to 0x08.
        do_fetch(0, $urandom);
        do_exec(0, 1'b0, 32'd0);
        chk("pc_at_0x10", PC, 32'h10);
        do_fetch(1, $urandom);
        do_exec(0, 1'b1, 32'hFFFF_FFF8);
        chk("branch_back", imem_addr, 32'h08);

        // Three stall cycles, then a delayed-ack fetch.
        do_fetch(2, $urandom);
        do_exec(3, 1'b1, 32'h18);
        chk("pc_at_0x20", imem_addr, 32'h20);
        do_fetch(5, 32'hDEAD_BEEF);
        chk("late_instr", instr, 32'hDEAD_BEEF);
        do_exec(0, 1'b0, 32'd0);

        // Wrap-around through the top of the address space.
        do_fetch(0, $urandom);
        do_exec(1, 1'b1, 32'hFFFF_FFFC - m_pc);
        do_fetch(0, $urandom);
        do_exec(0, 1'b0, 32'd0);
        chk("wrap_pc", PC, 32'd0);

        // Reset asserted mid-fetch at PC 0x20 takes effect without a clock edge.
        do_fetch(0, $urandom);
        do_exec(0, 1'b1, 32'h20);
        imem_ack = 1'b0;
        step();
        chk("mid_pc_pre", PC, 32'h20);
        #2;
        apply_reset();

        // Randomized transactions.
        for (int t = 0; t < 60; t++) begin
            logic [31:0] imm;
`ifdef MISALIGN_TRAP_EN
            imm = $urandom & 32'hFFFF_FFFC;
`else
            imm = $urandom;
`endif
            do_fetch($urandom_range(0, 6), $urandom);
            do_exec($urandom_range(0, 4), 1'($urandom), imm);
        end

        // Misaligned taken branch from PC 0.
        apply_reset();
        do_fetch(0, $urandom);
`ifdef MISALIGN_TRAP_EN
        stall = 1'b0; PCsrc = 1'b1; ImmExt = 32'h6;
        step();
        PCsrc = 1'b0;
        for (int i = 0; i < 4; i++) begin
            imem_ack = 1'($urandom);
            chk("trap_flag",  {31'd0, trap}, 32'd1);
            chk("trap_req",   {31'd0, imem_req}, 32'd0);
            chk("trap_valid", {31'd0, instr_valid}, 32'd0);
            chk("trap_pc",    PC, 32'd0);
            step();
        end
        apply_reset();
        chk("trap_clear", {31'd0, trap}, 32'd0);
`else
        do_exec(0, 1'b1, 32'h6);
        chk("misalign_addr", imem_addr, 32'h04);
        chk("misalign_trap", {31'd0, trap}, 32'd0);
        do_fetch(1, $urandom);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
